// File: rtl/modulo_job_queue.sv
// Operand FIFO and job sequencer in front of the modulo core: buffers operand pairs,
// issues each as a start pulse, waits for the core result and tags errors.
module modulo_job_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [15:0]              in_a_i,
  input  logic [15:0]              in_b_i,
  output logic [15:0]              Zahl1_o,
  output logic [15:0]              Zahl2_o,
  output logic                     start_o,
  input  logic                     core_valid_i,
  input  logic [15:0]              core_result_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [15:0]              out_result_o,
  output logic [1:0]               out_err_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int DATA_W = 16;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int TW     = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_DIVZERO = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [2*DATA_W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [CW-1:0]           r_count;

  logic [DATA_W-1:0]       r_zahl1;
  logic [DATA_W-1:0]       r_zahl2;
  logic [DATA_W-1:0]       r_result;
  logic [1:0]              r_err;
  logic [TW-1:0]           r_timer;
  logic                    r_armed;

  logic                    w_in_ready;
  logic                    w_push;
  logic                    w_pop;
  logic [2*DATA_W-1:0]     w_head;
  logic [DATA_W-1:0]       w_head_a;
  logic [DATA_W-1:0]       w_head_b;
  logic                    w_head_b_zero;
  logic                    w_accept;
  logic                    w_timeout;

  // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
  assign w_in_ready    = (r_count < CW'(DEPTH));
  assign w_push        = in_valid_i && w_in_ready;
  assign w_pop         = (r_state == S_IDLE) && (r_count != '0);
  assign w_head        = r_mem[r_rptr];
  assign w_head_a      = w_head[2*DATA_W-1:DATA_W];
  assign w_head_b      = w_head[DATA_W-1:0];
  assign w_head_b_zero = (w_head_b == '0);
  assign w_accept      = r_armed && core_valid_i;
  assign w_timeout     = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {in_a_i, in_b_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt = w_head_b_zero ? S_OUT : S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_accept || w_timeout) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // armed only sets after core_valid_i has been seen low, so a level left high by the
  // previous job cannot complete this one.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_zahl1  <= '0;
      r_zahl2  <= '0;
      r_result <= '0;
      r_err    <= ERR_OK;
      r_timer  <= '0;
      r_armed  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_zahl1 <= w_head_a;
            r_zahl2 <= w_head_b;
            if (w_head_b_zero) begin
              r_result <= '0;
              r_err    <= ERR_DIVZERO;
            end
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_armed <= 1'b0;
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (!core_valid_i) begin
            r_armed <= 1'b1;
          end
          if (w_accept) begin
            r_result <= core_result_i;
            r_err    <= ERR_OK;
          end else if (w_timeout) begin
            r_result <= '0;
            r_err    <= ERR_TIMEOUT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready_o   = w_in_ready;
  assign Zahl1_o      = r_zahl1;
  assign Zahl2_o      = r_zahl2;
  assign start_o      = (r_state == S_ISSUE);
  assign out_valid_o  = (r_state == S_OUT);
  assign out_result_o = r_result;
  assign out_err_o    = r_err;
  assign busy_o       = (r_state != S_IDLE);
  assign count_o      = r_count;

endmodule

// File: tb/tb_modulo_job_queue.sv
// Directed bench for modulo_job_queue: a vector table of single jobs plus scripted
// sequences for full FIFO, stale core valid and mid-job reset.
module tb_modulo_job_queue;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int NEVER   = 255;

  logic        clk;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_a_i;
  logic [15:0] in_b_i;
  logic [15:0] Zahl1_o;
  logic [15:0] Zahl2_o;
  logic        start_o;
  logic        core_valid_i;
  logic [15:0] core_result_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_result_o;
  logic [1:0]  out_err_o;
  logic        busy_o;
  logic [2:0]  count_o;

  int checks;
  int failures;

  modulo_job_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_a_i       (in_a_i),
    .in_b_i       (in_b_i),
    .Zahl1_o      (Zahl1_o),
    .Zahl2_o      (Zahl2_o),
    .start_o      (start_o),
    .core_valid_i (core_valid_i),
    .core_result_i(core_result_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_result_o (out_result_o),
    .out_err_o    (out_err_o),
    .busy_o       (busy_o),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] cres;
    int          delay;
    logic [15:0] exp_res;
    logic [1:0]  exp_err;
    int          exp_lat;
    int          exp_starts;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    in_valid_i    = 1'b0;
    in_a_i        = '0;
    in_b_i        = '0;
    core_valid_i  = 1'b0;
    core_result_i = '0;
    out_ready_i   = 1'b0;
    rst_i         = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  // Push one pair at cycle 0, model the core (valid rises delay cycles after start), check result.
  task automatic run_vec(input int idx);
    int cyc;
    int st;
    int starts;
    int lat;
    vec_t v;
    v = vecs[idx];
    st = -1;
    starts = 0;
    lat = -1;
    in_a_i = v.a;
    in_b_i = v.b;
    in_valid_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    chk($sformatf("v%0d_count1", idx), count_o, 1);
    cyc = 1;
    while (cyc < 40) begin
      if (start_o) begin
        starts++;
        if (st < 0) st = cyc;
        chk($sformatf("v%0d_zahl1_at_start", idx), Zahl1_o, v.a);
        chk($sformatf("v%0d_zahl2_at_start", idx), Zahl2_o, v.b);
      end
      if (out_valid_o) begin
        lat = cyc;
        break;
      end
      core_result_i = v.cres;
      core_valid_i = (v.delay != NEVER) && (st >= 0) && (cyc >= st + v.delay);
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_starts", idx), starts, v.exp_starts);
    chk($sformatf("v%0d_result", idx), out_result_o, v.exp_res);
    chk($sformatf("v%0d_err", idx), out_err_o, v.exp_err);
    chk($sformatf("v%0d_zahl1_out", idx), Zahl1_o, v.a);
    @(negedge clk);
    chk($sformatf("v%0d_valid_held", idx), out_valid_o, 1);
    chk($sformatf("v%0d_result_held", idx), out_result_o, v.exp_res);
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    core_valid_i = 1'b0;
    chk($sformatf("v%0d_valid_drop", idx), out_valid_o, 0);
    chk($sformatf("v%0d_idle", idx), busy_o, 0);
  endtask

  initial begin
    int idx;
    int nout;
    int starts_seen;
    logic drop;

    checks = 0;
    failures = 0;

    vecs[0] = '{a:16'd17,    b:16'd5,    cres:16'd2,   delay:6,     exp_res:16'd2,  exp_err:2'd0, exp_lat:9,  exp_starts:1};
    vecs[1] = '{a:16'd100,   b:16'd7,    cres:16'd2,   delay:2,     exp_res:16'd2,  exp_err:2'd0, exp_lat:5,  exp_starts:1};
    vecs[2] = '{a:16'd9,     b:16'd0,    cres:16'd7,   delay:3,     exp_res:16'd0,  exp_err:2'd1, exp_lat:2,  exp_starts:0};
    vecs[3] = '{a:16'hFFFF,  b:16'h0010, cres:16'h000F, delay:4,    exp_res:16'h000F, exp_err:2'd0, exp_lat:7, exp_starts:1};
    vecs[4] = '{a:16'd50,    b:16'd3,    cres:16'd2,   delay:NEVER, exp_res:16'd0,  exp_err:2'd2, exp_lat:11, exp_starts:1};
    vecs[5] = '{a:16'd50,    b:16'd3,    cres:16'd2,   delay:8,     exp_res:16'd2,  exp_err:2'd0, exp_lat:11, exp_starts:1};
    vecs[6] = '{a:16'd50,    b:16'd3,    cres:16'd2,   delay:9,     exp_res:16'd0,  exp_err:2'd2, exp_lat:11, exp_starts:1};
    vecs[7] = '{a:16'd5,     b:16'd9,    cres:16'd5,   delay:3,     exp_res:16'd5,  exp_err:2'd0, exp_lat:6,  exp_starts:1};
    vecs[8] = '{a:16'h1234,  b:16'd0,    cres:16'h5555, delay:2,    exp_res:16'd0,  exp_err:2'd1, exp_lat:2,  exp_starts:0};

    // Reset state
    do_reset();
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_start", start_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_zahl1", Zahl1_o, 0);
    chk("rst_zahl2", Zahl2_o, 0);
    chk("rst_result", out_result_o, 0);
    chk("rst_err", out_err_o, 0);
    chk("rst_count", count_o, 0);

    for (int i = 0; i < 9; i++) begin
      run_vec(i);
    end

    // Stale valid: core_valid_i stays high from job 1 into job 2
    do_reset();
    nout = 0;
    starts_seen = 0;
    out_ready_i = 1'b1;
    for (int c = 0; c < 21; c++) begin
      if (start_o) begin
        starts_seen++;
        chk($sformatf("stale_start_c%0d", c), ((c == 2) || (c == 8)) ? 1 : 0, 1);
      end
      if (out_valid_o) begin
        nout++;
        chk($sformatf("stale_out_cycle_c%0d", c), ((c == 6) || (c == 15)) ? 1 : 0, 1);
        chk($sformatf("stale_result_c%0d", c), out_result_o, 16'd2);
        chk($sformatf("stale_err_c%0d", c), out_err_o, 0);
      end
      in_valid_i    = (c <= 1);
      in_a_i        = (c == 0) ? 16'd20 : 16'd30;
      in_b_i        = (c == 0) ? 16'd6 : 16'd7;
      core_valid_i  = ((c >= 5) && (c <= 12)) || (c >= 14);
      core_result_i = ((c >= 7) && (c <= 13)) ? 16'h1111 : 16'd2;
      @(negedge clk);
    end
    chk("stale_nout", nout, 2);
    chk("stale_nstart", starts_seen, 2);
    in_valid_i = 1'b0;
    core_valid_i = 1'b0;
    out_ready_i = 1'b0;

    // Full FIFO with the output stalled, then drain in push order
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      in_a_i = 16'(i);
      in_b_i = 16'd0;
      in_valid_i = 1'b1;
      @(negedge clk);
    end
    in_a_i = 16'd6;
    chk("full_count", count_o, 4);
    chk("full_in_ready", in_ready_o, 0);
    chk("full_out_valid", out_valid_o, 1);
    chk("full_head_zahl1", Zahl1_o, 1);
    chk("full_err", out_err_o, 1);
    @(negedge clk);
    @(negedge clk);
    chk("full_count_hold", count_o, 4);
    chk("full_in_ready_hold", in_ready_o, 0);
    chk("full_zahl1_hold", Zahl1_o, 1);
    out_ready_i = 1'b1;
    idx = 1;
    for (int c = 0; c < 40 && idx <= 6; c++) begin
      drop = in_valid_i && in_ready_o;
      if (out_valid_o) begin
        chk($sformatf("drain_order_%0d", idx), Zahl1_o, idx);
        chk($sformatf("drain_err_%0d", idx), out_err_o, 1);
        idx++;
      end
      @(negedge clk);
      if (drop) in_valid_i = 1'b0;
    end
    chk("drain_total", idx - 1, 6);
    out_ready_i = 1'b0;
    @(negedge clk);
    chk("drain_in_ready", in_ready_o, 1);
    chk("drain_count", count_o, 0);

    // Reset in WAIT with 3 entries queued
    do_reset();
    for (int c = 0; c < 4; c++) begin
      in_a_i = 16'(c + 1);
      in_b_i = 16'd3;
      in_valid_i = 1'b1;
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    chk("mid_busy_before", busy_o, 1);
    chk("mid_count_before", count_o, 3);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("mid_count", count_o, 0);
    chk("mid_busy", busy_o, 0);
    chk("mid_out_valid", out_valid_o, 0);
    chk("mid_in_ready", in_ready_o, 1);
    @(negedge clk);
    chk("mid_no_start", start_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
